// File: rtl/soc_mini_pkg.sv
// soc_mini_pkg: shared constants and types for the register-chain demo SoC
package soc_mini_pkg;
  localparam int NUM_REGS = 32;
  localparam int DATA_W = 16;
  localparam int SEL_W = 8;
  localparam int INIT_W = 8;
  localparam int IDX_W = $clog2(NUM_REGS);
  typedef logic [DATA_W-1:0] chain_word_t;
  typedef logic [SEL_W-1:0] chain_idx_t;
endpackage

// File: rtl/chain_regfile.sv
// chain_regfile: accumulating r0 followed by a free-running shift chain
import soc_mini_pkg::*;
module chain_regfile (
  input  logic              clk,
  input  logic              resetn,
  input  logic [INIT_W-1:0] init_num,
  input  logic [IDX_W-1:0]  rd_idx,
  output chain_word_t       rd_data
);
  chain_word_t r [NUM_REGS];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) r[i] <= '0;
    end else begin
      r[0] <= r[0] + chain_word_t'(init_num);
      for (int i = 1; i < NUM_REGS; i++) r[i] <= r[i-1];
    end
  end
  assign rd_data = r[rd_idx];
endmodule

// File: rtl/soc_mini_top.sv
// soc_mini_top: board top showing the switch-selected chain register on the leds
import soc_mini_pkg::*;
module soc_mini_top (
  input  logic              clk,
  input  logic              resetn,
  input  logic [SEL_W-1:0]  switch,
  input  logic [INIT_W-1:0] init_num,
  output logic [DATA_W-1:0] led
);
  chain_word_t rd_data;
  chain_regfile u_chain (
    .clk(clk),
    .resetn(resetn),
    .init_num(init_num),
    .rd_idx(switch[IDX_W-1:0]),
    .rd_data(rd_data)
  );
  always_comb led = (32'(switch) < NUM_REGS) ? rd_data : '0;
endmodule

// File: tb/tb_soc_mini_top.sv
// tb_soc_mini_top: directed checks of reset, shift latency, selection, wrap and init changes
module tb_soc_mini_top;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [7:0] switch = 8'd5;
  logic [7:0] init_num = 8'd2;
  logic [15:0] led;
  int vectors = 0;
  int miscompares = 0;
  soc_mini_top dut (
    .clk(clk),
    .resetn(resetn),
    .switch(switch),
    .init_num(init_num),
    .led(led)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] exp);
    vectors++;
    assert (led === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, led, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic sel(input logic [7:0] s, input string tag, input logic [15:0] exp);
    switch = s;
    #1;
    chk(tag, exp);
  endtask
  initial begin
    for (int i = 0; i < 20; i++) begin
      #50;
      chk("reset_hold", 16'h0000);
      #50;
    end
    resetn = 1'b1;
    for (int k = 1; k <= 49; k++) begin
      step();
      chk("ripple_sw5", (k > 5) ? 16'(2 * (k - 5)) : 16'h0000);
      if (k == 20) begin
        sel(8'd31, "sw31_early", 16'h0000);
        switch = 8'd5;
      end
    end
    sel(8'd0, "sw0_k49", 16'd98);
    sel(8'd31, "sw31_k49", 16'd36);
    sel(8'd32, "sw32_oor", 16'h0000);
    sel(8'hFF, "swFF_oor", 16'h0000);
    switch = 8'd31;
    step();
    chk("sw31_k50", 16'd38);
    #3;
    resetn = 1'b0;
    #1;
    chk("midreset_sw31", 16'h0000);
    sel(8'd0, "midreset_sw0", 16'h0000);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("restart_r0", 16'(2 * k));
    end
    init_num = 8'd3;
    switch = 8'd0;
    step();
    chk("inc_r0_e11", 16'd23);
    sel(8'd1, "inc_r1_e11", 16'd20);
    switch = 8'd0;
    step();
    chk("inc_r0_e12", 16'd26);
    sel(8'd1, "inc_r1_e12", 16'd23);
    switch = 8'd0;
    step();
    chk("inc_r0_e13", 16'd29);
    sel(8'd1, "inc_r1_e13", 16'd26);
    @(negedge clk);
    resetn = 1'b0;
    init_num = 8'hFF;
    switch = 8'd0;
    #1;
    chk("wrap_reset", 16'h0000);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= 256; k++) step();
    chk("wrap_e256", 16'hFF00);
    step();
    chk("wrap_e257", 16'hFFFF);
    step();
    chk("wrap_e258", 16'h00FE);
    sel(8'd31, "wrap_r31_e258", 16'hE21D);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
